demux_1_n_reg_v: RTL and testbench



---
 rtl/demux_1_n_reg_v.sv | 85 ++++++++
 tb/tb_demux_1_n_reg_v.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1_n_reg_v.sv
// Registered 1-to-N demultiplexer with valid/ready on the input and on every
// output channel. Binary select (unicast) or bit-mask select (multicast).
// Each channel holds one word; words with no destination are counted and dropped.
module demux_1_n_reg_v #(
    parameter int unsigned N_CH      = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MASK_MODE = 0,
    localparam int unsigned SEL_W    = (MASK_MODE != 0) ? N_CH : $clog2(N_CH)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [DATA_W-1:0]        i_data,
    input  logic [SEL_W-1:0]         i_sel,
    output logic [N_CH-1:0]          o_valid,
    input  logic [N_CH-1:0]          i_ready,
    output logic [N_CH*DATA_W-1:0]   o_data,
    output logic [15:0]              o_drop_cnt,
    output logic                     o_busy
);

    localparam int unsigned CNT_W = 16;

    logic [N_CH-1:0]        tgt_c;
    logic [N_CH-1:0]        can_acc_c;
    logic [N_CH-1:0]        load_c;
    logic                   xfer_c;
    logic                   drop_c;

    logic [N_CH-1:0]        valid_q, valid_d;
    logic [N_CH*DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]       drop_cnt_q, drop_cnt_d;

    // Target set decode: mask bits directly, or index compare (out of range -> empty)
    generate
        if (MASK_MODE != 0) begin : g_mask
            assign tgt_c = i_sel;
        end else begin : g_bin
            always_comb begin
                tgt_c = '0;
                for (int unsigned k = 0; k < N_CH; k++) begin
                    if (i_sel == SEL_W'(k)) tgt_c[k] = 1'b1;
                end
            end
        end
    endgenerate

    // A channel accepts when empty or draining this cycle; all targets must accept
    assign can_acc_c = ~valid_q | i_ready;
    assign o_ready   = &(can_acc_c | ~tgt_c);
    assign xfer_c    = i_valid & o_ready;
    assign load_c    = tgt_c & {N_CH{xfer_c}};
    assign drop_c    = xfer_c & ~(|tgt_c);

    // Next state: drain clears, load sets (load wins so drain+load has no bubble)
    always_comb begin
        valid_d    = (valid_q & ~i_ready) | load_c;
        data_d     = data_q;
        drop_cnt_d = drop_cnt_q;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (load_c[k]) data_d[k*DATA_W +: DATA_W] = i_data;
        end
        if (drop_c && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end

    // State registers, cleared asynchronously
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q    <= '0;
            data_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            data_q     <= data_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_drop_cnt = drop_cnt_q;
    assign o_busy     = |valid_q;

endmodule

// File: tb/tb_demux_1_n_reg_v.sv
// Bench for demux_1_n_reg_v: three configurations (unicast 8ch, unicast 6ch,
// multicast 4ch), a vector table, directed corner sequences and a random
// stream scored against per-channel expected-word queues.
module tb_demux_1_n_reg_v;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: N_CH=8, unicast
    logic        a_v = 1'b0, a_ordy, a_busy;
    logic [7:0]  a_d = '0;
    logic [2:0]  a_sel = '0;
    logic [7:0]  a_ov, a_rdy = '0;
    logic [63:0] a_od;
    logic [15:0] a_cnt;
    // Instance B: N_CH=6, unicast
    logic        b_v = 1'b0, b_ordy, b_busy;
    logic [7:0]  b_d = '0;
    logic [2:0]  b_sel = '0;
    logic [5:0]  b_ov, b_rdy = '0;
    logic [47:0] b_od;
    logic [15:0] b_cnt;
    // Instance C: N_CH=4, multicast
    logic        c_v = 1'b0, c_ordy, c_busy;
    logic [7:0]  c_d = '0;
    logic [3:0]  c_sel = '0;
    logic [3:0]  c_ov, c_rdy = '0;
    logic [31:0] c_od;
    logic [15:0] c_cnt;

    demux_1_n_reg_v #(.N_CH(8), .DATA_W(8), .MASK_MODE(0)) u_a (
        .i_clk(clk), .i_rst(rst), .i_valid(a_v), .o_ready(a_ordy), .i_data(a_d),
        .i_sel(a_sel), .o_valid(a_ov), .i_ready(a_rdy), .o_data(a_od),
        .o_drop_cnt(a_cnt), .o_busy(a_busy));
    demux_1_n_reg_v #(.N_CH(6), .DATA_W(8), .MASK_MODE(0)) u_b (
        .i_clk(clk), .i_rst(rst), .i_valid(b_v), .o_ready(b_ordy), .i_data(b_d),
        .i_sel(b_sel), .o_valid(b_ov), .i_ready(b_rdy), .o_data(b_od),
        .o_drop_cnt(b_cnt), .o_busy(b_busy));
    demux_1_n_reg_v #(.N_CH(4), .DATA_W(8), .MASK_MODE(1)) u_c (
        .i_clk(clk), .i_rst(rst), .i_valid(c_v), .o_ready(c_ordy), .i_data(c_d),
        .i_sel(c_sel), .o_valid(c_ov), .i_ready(c_rdy), .o_data(c_od),
        .o_drop_cnt(c_cnt), .o_busy(c_busy));

    typedef struct packed {
        logic [2:0]  sel;
        logic        v;
        logic [7:0]  d;
        logic [5:0]  rdy;
        logic        exp_r;
        logic [5:0]  exp_ov;
        logic [7:0]  exp_d2;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl [9];

    // Reference model: expected words per channel (index inst*8+k) and drop count
    logic [7:0]  sb [24][$];
    logic [15:0] m_cnt [3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input int inst, input logic v, input logic [7:0] d,
                         input logic [7:0] sel, input logic [7:0] rdy);
        case (inst)
            0: begin a_v = v; a_d = d; a_sel = sel[2:0]; a_rdy = rdy; end
            1: begin b_v = v; b_d = d; b_sel = sel[2:0]; b_rdy = rdy[5:0]; end
            default: begin c_v = v; c_d = d; c_sel = sel[3:0]; c_rdy = rdy[3:0]; end
        endcase
    endtask

    task automatic read(input int inst, output logic [7:0] ov, output logic [63:0] od,
                        output logic r, output logic [15:0] cnt, output logic bz);
        case (inst)
            0: begin ov = a_ov; od = a_od; r = a_ordy; cnt = a_cnt; bz = a_busy; end
            1: begin ov = 8'(b_ov); od = 64'(b_od); r = b_ordy; cnt = b_cnt; bz = b_busy; end
            default: begin ov = 8'(c_ov); od = 64'(c_od); r = c_ordy; cnt = c_cnt; bz = c_busy; end
        endcase
    endtask

    // One cycle against the model: check state and o_ready, then advance the model
    task automatic step(input int inst, input logic v, input logic [7:0] d,
                        input logic [7:0] sel, input logic [7:0] rdy, output bit acc);
        int          n;
        bit          mm;
        logic [7:0]  tgt, ov;
        logic [63:0] od;
        logic        r, bz, exp_r;
        logic [15:0] cnt;
        n  = (inst == 0) ? 8 : (inst == 1) ? 6 : 4;
        mm = (inst == 2);
        drive(inst, v, d, sel, rdy);
        #1;
        read(inst, ov, od, r, cnt, bz);
        for (int k = 0; k < n; k++) begin
            chk("stream_valid", 64'(ov[k]), 64'(sb[inst*8+k].size() != 0));
            if (sb[inst*8+k].size() != 0)
                chk("stream_data", 64'(od[k*8 +: 8]), 64'(sb[inst*8+k][0]));
        end
        chk("stream_busy", 64'(bz), 64'(ov != 0));
        chk("stream_cnt", 64'(cnt), 64'(m_cnt[inst]));
        tgt = '0;
        if (mm) tgt = sel & 8'((1 << n) - 1);
        else if (int'(sel) < n) tgt[sel[2:0]] = 1'b1;
        exp_r = 1'b1;
        for (int k = 0; k < n; k++)
            if (tgt[k] && sb[inst*8+k].size() != 0 && !rdy[k]) exp_r = 1'b0;
        chk("stream_ready", 64'(r), 64'(exp_r));
        @(posedge clk);
        for (int k = 0; k < n; k++)
            if (sb[inst*8+k].size() != 0 && rdy[k]) void'(sb[inst*8+k].pop_front());
        acc = v && exp_r;
        if (acc) begin
            if (tgt == 0) begin
                if (m_cnt[inst] != 16'hFFFF) m_cnt[inst] = m_cnt[inst] + 16'd1;
            end else begin
                for (int k = 0; k < n; k++) if (tgt[k]) sb[inst*8+k].push_back(d);
            end
        end
        @(negedge clk);
    endtask

    task automatic stream(input int inst);
        int acc_n = 0;
        int cyc   = 0;
        bit acc;
        logic v;
        logic [7:0] sel;
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 8'h00, 8'h00);
        drive(1, 1'b0, 8'h00, 8'h00, 8'h00);
        drive(2, 1'b0, 8'h00, 8'h00, 8'h00);
        rst = 1'b1;
        #2 rst = 1'b0;
        for (int i = 0; i < 24; i++) sb[i].delete();
        for (int i = 0; i < 3; i++) m_cnt[i] = '0;
        @(negedge clk);
        while (acc_n < 100 && cyc < 3000) begin
            v   = ($urandom_range(0, 3) != 0);
            sel = (inst == 2) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 7));
            step(inst, v, 8'($urandom), sel, 8'($urandom), acc);
            if (acc) acc_n++;
            cyc++;
        end
        chk("stream_words", 64'(acc_n), 64'd100);
        repeat (4) step(inst, 1'b0, 8'h00, 8'h00, 8'hFF, acc);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        tbl[0] = '{3'd2, 1'b1, 8'h10, 6'h00, 1'b1, 6'b000100, 8'h10, 16'd0};
        tbl[1] = '{3'd2, 1'b1, 8'h20, 6'h00, 1'b0, 6'b000100, 8'h10, 16'd0};
        tbl[2] = '{3'd5, 1'b1, 8'h30, 6'h00, 1'b1, 6'b100100, 8'h10, 16'd0};
        tbl[3] = '{3'd7, 1'b1, 8'h40, 6'h00, 1'b1, 6'b100100, 8'h10, 16'd1};
        tbl[4] = '{3'd6, 1'b0, 8'h00, 6'h00, 1'b1, 6'b100100, 8'h10, 16'd1};
        tbl[5] = '{3'd2, 1'b0, 8'h00, 6'h00, 1'b0, 6'b100100, 8'h10, 16'd1};
        tbl[6] = '{3'd2, 1'b1, 8'h50, 6'h04, 1'b1, 6'b100100, 8'h50, 16'd1};
        tbl[7] = '{3'd0, 1'b1, 8'h60, 6'h3F, 1'b1, 6'b000001, 8'h50, 16'd1};
        tbl[8] = '{3'd0, 1'b0, 8'h00, 6'h3F, 1'b1, 6'b000000, 8'h50, 16'd1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_a_valid", 64'(a_ov), 64'd0);
        chk("rst_a_data", a_od, 64'd0);
        chk("rst_a_busy", 64'(a_busy), 64'd0);
        chk("rst_a_ready", 64'(a_ordy), 64'd1);
        chk("rst_b_cnt", 64'(b_cnt), 64'd0);
        chk("rst_c_valid", 64'(c_ov), 64'd0);
        @(negedge clk);

        // Vector table on the 6-channel unicast instance
        for (int i = 0; i < 9; i++) begin
            b_sel = tbl[i].sel; b_v = tbl[i].v; b_d = tbl[i].d; b_rdy = tbl[i].rdy;
            #1;
            chk("tbl_ready", 64'(b_ordy), 64'(tbl[i].exp_r));
            tick();
            chk("tbl_valid", 64'(b_ov), 64'(tbl[i].exp_ov));
            chk("tbl_ch2_data", 64'(b_od[16 +: 8]), 64'(tbl[i].exp_d2));
            chk("tbl_cnt", 64'(b_cnt), 64'(tbl[i].exp_cnt));
            chk("tbl_busy", 64'(b_busy), 64'(tbl[i].exp_ov != 0));
        end
        b_v = 1'b0;

        // Asynchronous reset while channels are full
        a_rdy = 8'h00; a_v = 1'b1; a_sel = 3'd1; a_d = 8'h3C;
        c_rdy = 4'h0;  c_v = 1'b1; c_sel = 4'b0011; c_d = 8'h5A;
        tick();
        a_v = 1'b0; c_v = 1'b0;
        chk("pre_rst_a_valid", 64'(a_ov), 64'h02);
        chk("pre_rst_c_valid", 64'(c_ov), 64'h3);
        #2 rst = 1'b1;
        #1;
        chk("arst_a_valid", 64'(a_ov), 64'd0);
        chk("arst_a_data", a_od, 64'd0);
        chk("arst_a_busy", 64'(a_busy), 64'd0);
        chk("arst_b_cnt", 64'(b_cnt), 64'd0);
        chk("arst_c_valid", 64'(c_ov), 64'd0);
        chk("arst_c_data", 64'(c_od), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Unicast to channel 3, drained next cycle
        a_rdy = 8'hFF; a_v = 1'b1; a_sel = 3'd3; a_d = 8'hA5;
        #1 chk("uni_ready", 64'(a_ordy), 64'd1);
        tick();
        a_v = 1'b0;
        chk("uni_valid", 64'(a_ov), 64'h08);
        chk("uni_data", 64'(a_od[24 +: 8]), 64'hA5);
        chk("uni_busy", 64'(a_busy), 64'd1);
        tick();
        chk("uni_drained", 64'(a_ov), 64'h00);

        // Backpressure on channel 3, then drain+load without a bubble
        a_rdy = 8'hF7; a_v = 1'b1; a_sel = 3'd3; a_d = 8'h11;
        #1 chk("bp_ready1", 64'(a_ordy), 64'd1);
        tick();
        a_d = 8'h22;
        #1 chk("bp_ready2", 64'(a_ordy), 64'd0);
        chk("bp_hold_data", 64'(a_od[24 +: 8]), 64'h11);
        tick();
        chk("bp_stable_valid", 64'(a_ov), 64'h08);
        chk("bp_stable_data", 64'(a_od[24 +: 8]), 64'h11);
        a_rdy = 8'hFF;
        #1 chk("bp_ready3", 64'(a_ordy), 64'd1);
        tick();
        a_v = 1'b0;
        chk("bp_nobubble_valid", 64'(a_ov), 64'h08);
        chk("bp_nobubble_data", 64'(a_od[24 +: 8]), 64'h22);
        tick();
        chk("bp_drained", 64'(a_ov), 64'h00);

        // Multicast all-or-nothing with channel 2 blocked
        c_rdy = 4'h0; c_v = 1'b1; c_sel = 4'b0100; c_d = 8'h77;
        tick();
        c_sel = 4'b0101; c_d = 8'h99;
        #1 chk("mc_blocked_ready", 64'(c_ordy), 64'd0);
        tick();
        chk("mc_blocked_valid", 64'(c_ov), 64'h4);
        chk("mc_ch0_untouched", 64'(c_od[7:0]), 64'h00);
        chk("mc_ch2_hold", 64'(c_od[23:16]), 64'h77);
        c_rdy = 4'b0100;
        #1 chk("mc_release_ready", 64'(c_ordy), 64'd1);
        tick();
        c_v = 1'b0;
        chk("mc_valid", 64'(c_ov), 64'h5);
        chk("mc_ch0_data", 64'(c_od[7:0]), 64'h99);
        chk("mc_ch2_data", 64'(c_od[23:16]), 64'h99);
        c_rdy = 4'hF;
        tick();
        chk("mc_drained", 64'(c_ov), 64'h0);

        // Random streams against the queue model
        stream(0);
        stream(2);

        // Drop counter saturation on the 6-channel instance (count is 0 after reset)
        b_rdy = 6'h3F; b_v = 1'b1; b_sel = 3'd7; b_d = 8'hEE;
        #1 chk("sat_drop_ready", 64'(b_ordy), 64'd1);
        repeat (65534) @(posedge clk);
        @(negedge clk);
        chk("sat_cnt_fffe", 64'(b_cnt), 64'hFFFE);
        chk("sat_no_valid", 64'(b_ov), 64'h00);
        tick();
        chk("sat_cnt_ffff", 64'(b_cnt), 64'hFFFF);
        tick();
        chk("sat_cnt_hold", 64'(b_cnt), 64'hFFFF);
        b_v = 1'b0;
        acc = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
